imem_program_encoder: RTL

- Sequential instruction encoder and loader that runs in the opposite direction to the processor's instruction decode path.
- Accepts a stream of symbolic instructions: operation code, register numbers and an immediate/target field.
- Packs each one into the 32-bit MIPS32 word that the control unit decodes, including the DSP ADDU.QB/ADDU_S.QB forms and the codebase's JR encoding.
- Writes the words to consecutive instruction-memory addresses through a backpressured write port; used for program loading in simulation and in the boot path.

---
 rtl/imem_program_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imem_program_encoder.sv
// Symbolic-instruction to MIPS32 word encoder that streams encoded words into
// consecutive instruction-memory addresses through a backpressured write port.
//
// state | meaning
// IDLE  | waiting for start; write port idle
// LOAD  | accepting instructions, encoding into the output register
// DRAIN | last instruction accepted, waiting for the output register to empty
// DONE  | one-cycle end-of-session, done asserted
module imem_program_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              err_illegal,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] OP_ADD       = 5'd0;
    localparam logic [4:0] OP_SUB       = 5'd1;
    localparam logic [4:0] OP_AND       = 5'd2;
    localparam logic [4:0] OP_OR        = 5'd3;
    localparam logic [4:0] OP_SLT       = 5'd4;
    localparam logic [4:0] OP_SLLV      = 5'd5;
    localparam logic [4:0] OP_SRLV      = 5'd6;
    localparam logic [4:0] OP_SRAV      = 5'd7;
    localparam logic [4:0] OP_LW        = 5'd8;
    localparam logic [4:0] OP_SW        = 5'd9;
    localparam logic [4:0] OP_BEQ       = 5'd10;
    localparam logic [4:0] OP_ADDI      = 5'd11;
    localparam logic [4:0] OP_J         = 5'd12;
    localparam logic [4:0] OP_JAL       = 5'd13;
    localparam logic [4:0] OP_JR        = 5'd14;
    localparam logic [4:0] OP_ADDU_QB   = 5'd15;
    localparam logic [4:0] OP_ADDU_S_QB = 5'd16;

    localparam logic [ADDR_W:0] WW_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   ww_q;
    logic              err_q;
    logic              done_q;

    logic [31:0] enc_d;
    logic        legal_d;
    logic        write;
    logic        accept;

    always_comb begin
        enc_d   = 32'h0;
        legal_d = 1'b1;
        case (in_op)
            OP_ADD:       enc_d = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
            OP_SUB:       enc_d = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
            OP_AND:       enc_d = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100100};
            OP_OR:        enc_d = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100101};
            OP_SLT:       enc_d = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
            OP_SLLV:      enc_d = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b000100};
            OP_SRLV:      enc_d = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b000110};
            OP_SRAV:      enc_d = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b000111};
            OP_LW:        enc_d = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            OP_SW:        enc_d = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            OP_BEQ:       enc_d = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            OP_ADDI:      enc_d = {6'b001000, in_rs, in_rt, in_imm[15:0]};
            OP_J:         enc_d = {6'b000010, in_imm};
            OP_JAL:       enc_d = {6'b000011, in_imm};
            // JR uses this codebase's private primary opcode, not SPECIAL/funct 001000
            OP_JR:        enc_d = {6'b000111, in_rs, 21'b0};
            OP_ADDU_QB:   enc_d = {6'b011111, in_rs, in_rt, in_rd, 5'b00000, 6'b010000};
            OP_ADDU_S_QB: enc_d = {6'b011111, in_rs, in_rt, in_rd, 5'b00100, 6'b010000};
            default:      legal_d = 1'b0;
        endcase
    end

    assign write    = we_q && imem_ready;
    assign in_ready = (state_q == LOAD) && (!we_q || imem_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            ww_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // addr_q names the held word while we_q=1, else the next free slot
            if (write) begin
                we_q   <= 1'b0;
                addr_q <= addr_q + ADDR_W'(1);
                if (ww_q != WW_MAX) ww_q <= ww_q + (ADDR_W+1)'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        ww_q    <= '0;
                        err_q   <= 1'b0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (legal_d) begin
                            we_q    <= 1'b1;
                            wdata_q <= enc_d;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (in_last) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!we_q || write) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign words_written = ww_q;
    assign err_illegal   = err_q;
    assign done          = done_q;

endmodule
